// File: rtl/io_channel_bank_pkg.sv
// Shared constants for the IO channel bank: channel numbers, status bit
// positions, word widths and the display handshake states.
package io_channel_bank_pkg;

  localparam int WORD_W = 15;
  localparam int KEY_W  = 5;
  localparam int CNT_W  = 5;

  localparam logic [2:0] CH_KEY   = 3'd0;
  localparam logic [2:0] CH_STAT  = 3'd1;
  localparam logic [2:0] CH_GEN0  = 3'd2;
  localparam logic [2:0] CH_GEN1  = 3'd3;
  localparam logic [2:0] CH_GEN2  = 3'd4;
  localparam logic [2:0] CH_GEN3  = 3'd5;
  localparam logic [2:0] CH_DISP  = 3'd6;
  localparam logic [2:0] CH_TIMER = 3'd7;

  localparam int STAT_OVF  = 14;
  localparam int STAT_BUSY = 13;

  typedef enum logic [0:0] {
    DISP_IDLE = 1'b0,
    DISP_SEND = 1'b1
  } disp_state_e;

endpackage

// File: rtl/io_channel_bank_if.sv
// Host-side bus of the IO channel bank: channel read/write port, keypad
// input and the display output handshake.
interface io_channel_bank_if;
  import io_channel_bank_pkg::*;

  logic [2:0]        IO_read_sel;
  logic              IO_read_en;
  logic [WORD_W-1:0] IO_read_data;
  logic [2:0]        IO_write_sel;
  logic              IO_write_en;
  logic [WORD_W-1:0] IO_write_data;
  logic              key_valid;
  logic [KEY_W-1:0]  key_code;
  logic              disp_valid;
  logic              disp_ready;
  logic [WORD_W-1:0] disp_data;

  modport master (
    output IO_read_sel, IO_read_en, IO_write_sel, IO_write_en, IO_write_data,
    output key_valid, key_code, disp_ready,
    input  IO_read_data, disp_valid, disp_data
  );

  modport slave (
    input  IO_read_sel, IO_read_en, IO_write_sel, IO_write_en, IO_write_data,
    input  key_valid, key_code, disp_ready,
    output IO_read_data, disp_valid, disp_data
  );

endinterface

// File: rtl/io_channel_bank_keycode_fifo.sv
// Keycode FIFO; a push into a full FIFO is accepted only when a pop frees
// a slot in the same cycle, and a pop of an empty FIFO does nothing.
module keycode_fifo
  import io_channel_bank_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [KEY_W-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [KEY_W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [KEY_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: head is masked by the consumer while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_channel_bank.sv
// Eight-channel IO bank: keycode FIFO, status, four general registers,
// a one-deep display handshake and a free-running timer.
module io_channel_bank
  import io_channel_bank_pkg::*;
#(
  parameter int KEY_DEPTH = 4,
  parameter int TIMER_W   = WORD_W
) (
  input  logic             clock,
  input  logic             reset,
  io_channel_bank_if.slave bus
);

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [KEY_W-1:0]  fifo_head;
  logic              key_pop;
  logic              overflow;
  logic [WORD_W-1:0] gen_q [4];
  logic [TIMER_W-1:0] timer;
  disp_state_e       disp_state;
  logic [WORD_W-1:0] disp_data_q;
  logic              disp_busy;
  logic              wr_stat;
  logic              wr_gen;
  logic              wr_disp;
  logic              wr_timer;
  logic [1:0]        wr_gen_idx;
  logic [1:0]        rd_gen_idx;
  logic [WORD_W-1:0] rd_data;

  assign key_pop    = bus.IO_read_en && (bus.IO_read_sel == CH_KEY);
  assign wr_stat    = bus.IO_write_en && (bus.IO_write_sel == CH_STAT);
  assign wr_gen     = bus.IO_write_en && (bus.IO_write_sel >= CH_GEN0) &&
                      (bus.IO_write_sel <= CH_GEN3);
  assign wr_disp    = bus.IO_write_en && (bus.IO_write_sel == CH_DISP);
  assign wr_timer   = bus.IO_write_en && (bus.IO_write_sel == CH_TIMER);
  assign wr_gen_idx = 2'(bus.IO_write_sel - CH_GEN0);
  assign rd_gen_idx = 2'(bus.IO_read_sel - CH_GEN0);
  assign disp_busy  = (disp_state == DISP_SEND);

  keycode_fifo #(.DEPTH(KEY_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.key_valid),
    .pop   (key_pop),
    .din   (bus.key_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // A full FIFO only loses the code when no pop frees a slot this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (bus.key_valid && fifo_full && !key_pop) begin
      overflow <= 1'b1;
    end else if (wr_stat && bus.IO_write_data[STAT_OVF]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) gen_q[i] <= '0;
    end else if (wr_gen) begin
      gen_q[wr_gen_idx] <= bus.IO_write_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (wr_timer) begin
      timer <= TIMER_W'(bus.IO_write_data);
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Writes arriving while a word is still pending are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_state  <= DISP_IDLE;
      disp_data_q <= '0;
    end else begin
      case (disp_state)
        DISP_IDLE: if (wr_disp) begin
          disp_data_q <= bus.IO_write_data;
          disp_state  <= DISP_SEND;
        end
        DISP_SEND: if (bus.disp_ready) disp_state <= DISP_IDLE;
        default:   disp_state <= DISP_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.IO_read_sel)
      CH_KEY:   rd_data = fifo_empty ? '0 : WORD_W'(fifo_head);
      CH_STAT: begin
        rd_data[STAT_OVF]    = overflow;
        rd_data[STAT_BUSY]   = disp_busy;
        rd_data[CNT_W-1:0]   = fifo_count;
      end
      CH_GEN0, CH_GEN1, CH_GEN2, CH_GEN3: rd_data = gen_q[rd_gen_idx];
      CH_DISP:  rd_data = disp_data_q;
      CH_TIMER: rd_data = WORD_W'(timer);
      default:  rd_data = '0;
    endcase
  end

  assign bus.IO_read_data = rd_data;
  assign bus.disp_valid   = disp_busy;
  assign bus.disp_data    = disp_data_q;

endmodule

// File: tb/tb_io_channel_bank.sv
// Directed bench for io_channel_bank: stimulus queues expected values and a
// negedge monitor drains the queue against the DUT outputs.
module tb_io_channel_bank;
  import io_channel_bank_pkg::*;

  logic clock;
  logic reset;
  io_channel_bank_if bus ();

  io_channel_bank #(.KEY_DEPTH(4), .TIMER_W(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // kind: 0 = IO_read_data, 1 = disp_valid, 2 = disp_data
  int          kind_q [$];
  logic [14:0] exp_q  [$];
  string       name_q [$];

  int          m_kind;
  logic [14:0] m_exp;
  logic [14:0] m_act;
  string       m_name;

  always @(negedge clock) begin
    while (kind_q.size() != 0) begin
      m_kind = kind_q.pop_front();
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      case (m_kind)
        1:       m_act = {14'b0, bus.disp_valid};
        2:       m_act = bus.disp_data;
        default: m_act = bus.IO_read_data;
      endcase
      total++;
      if (m_act !== m_exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [14:0] v, input string nm);
    kind_q.push_back(kind);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic go();
    @(posedge clock);
    #1;
    bus.IO_read_en  = 1'b0;
    bus.IO_write_en = 1'b0;
    bus.key_valid   = 1'b0;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [14:0] d);
    bus.IO_write_en   = 1'b1;
    bus.IO_write_sel  = ch;
    bus.IO_write_data = d;
  endtask

  task automatic rd(input logic [2:0] ch, input logic [14:0] e, input string nm,
                    input bit pop = 1'b0);
    bus.IO_read_sel = ch;
    bus.IO_read_en  = pop;
    expect_val(0, e, nm);
  endtask

  task automatic push_key(input logic [4:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    bus.IO_read_sel   = '0;
    bus.IO_read_en    = 1'b0;
    bus.IO_write_sel  = '0;
    bus.IO_write_en   = 1'b0;
    bus.IO_write_data = '0;
    bus.key_valid     = 1'b0;
    bus.key_code      = '0;
    bus.disp_ready    = 1'b0;

    // Reset state; strobes during reset must be ignored
    go(); rd(CH_STAT, 15'h0000, "rst_stat"); push_key(5'd9);
    expect_val(1, 15'h0000, "rst_disp_valid");
    expect_val(2, 15'h0000, "rst_disp_data");
    go(); rd(CH_TIMER, 15'h0000, "rst_timer"); wr(CH_TIMER, 15'h0123);
    go(); rd(CH_KEY, 15'h0000, "rst_key_empty"); reset = 1'b0;
    go(); rd(CH_STAT, 15'h0000, "post_rst_stat");

    // Push 3,7,9 then pop them back
    go(); push_key(5'd3);
    go(); push_key(5'd7);
    go(); push_key(5'd9);
    go(); rd(CH_STAT, 15'h0003, "cnt3");
    go(); rd(CH_KEY, 15'h0003, "pop3", 1'b1);
    go(); rd(CH_KEY, 15'h0007, "pop7", 1'b1);
    go(); rd(CH_KEY, 15'h0009, "pop9", 1'b1);
    go(); rd(CH_STAT, 15'h0000, "cnt0");
    go(); rd(CH_KEY, 15'h0000, "pop_empty", 1'b1);
    go(); rd(CH_STAT, 15'h0000, "pop_empty_noflag");

    // Overflow: five pushes into a depth-4 FIFO
    for (int c = 1; c <= 5; c++) begin
      go(); push_key(5'(c));
    end
    go(); rd(CH_STAT, 15'h4004, "ovf_set");
    go(); rd(CH_KEY, 15'h0001, "ovf_head");
    go(); wr(CH_STAT, 15'h4000); rd(CH_STAT, 15'h4004, "ovf_rw_same_cycle");
    go(); rd(CH_STAT, 15'h0004, "ovf_cleared");

    // Push and pop together while full, then drain
    go(); push_key(5'd17); rd(CH_KEY, 15'h0001, "full_pushpop", 1'b1);
    go(); rd(CH_STAT, 15'h0004, "full_pushpop_cnt");
    go(); rd(CH_KEY, 15'h0002, "drain2", 1'b1);
    go(); rd(CH_KEY, 15'h0003, "drain3", 1'b1);
    go(); rd(CH_KEY, 15'h0004, "drain4", 1'b1);
    go(); rd(CH_KEY, 15'h0011, "drain17", 1'b1);
    go(); rd(CH_STAT, 15'h0000, "drained");

    // Push and pop together while empty: push only
    go(); push_key(5'd21); rd(CH_KEY, 15'h0000, "empty_pushpop", 1'b1);
    go(); rd(CH_STAT, 15'h0001, "empty_pushpop_cnt");
    go(); rd(CH_KEY, 15'h0015, "pop21", 1'b1);
    go(); rd(CH_STAT, 15'h0000, "cnt0_again");

    // General registers, read in the write cycle returns the old value
    go(); wr(CH_GEN0, 15'h1111); rd(CH_GEN0, 15'h0000, "gen0_prewrite");
    go(); wr(CH_GEN1, 15'h2222); rd(CH_GEN0, 15'h1111, "gen0");
    go(); wr(CH_GEN2, 15'h7FFF); rd(CH_GEN1, 15'h2222, "gen1");
    go(); wr(CH_GEN3, 15'h0ABC); rd(CH_GEN2, 15'h7FFF, "gen2");
    go(); rd(CH_GEN3, 15'h0ABC, "gen3");

    // Display handshake with back-pressure
    go(); wr(CH_DISP, 15'h1234); rd(CH_DISP, 15'h0000, "disp_prewrite");
    expect_val(1, 15'h0000, "disp_idle_valid");
    for (int i = 0; i < 5; i++) begin
      go();
      expect_val(1, 15'h0001, "disp_hold_valid");
      expect_val(2, 15'h1234, "disp_hold_data");
      if (i == 1) begin
        wr(CH_DISP, 15'h0777);
        rd(CH_STAT, 15'h2000, "disp_busy");
      end
      if (i == 3) rd(CH_DISP, 15'h1234, "disp_read");
    end
    go(); bus.disp_ready = 1'b1; expect_val(1, 15'h0001, "disp_accept_valid");
    go(); bus.disp_ready = 1'b0; expect_val(1, 15'h0000, "disp_back_idle");
    rd(CH_STAT, 15'h0000, "disp_not_busy");
    expect_val(2, 15'h1234, "disp_data_held");

    // Timer load and wrap
    go(); wr(CH_TIMER, 15'h7FFE);
    go(); rd(CH_TIMER, 15'h7FFE, "timer_load");
    go(); rd(CH_TIMER, 15'h7FFF, "timer_7fff");
    go(); rd(CH_TIMER, 15'h0000, "timer_wrap");
    go(); rd(CH_TIMER, 15'h0001, "timer_after_wrap");

    // Asynchronous reset in SEND with two codes queued
    go(); push_key(5'd4);
    go(); push_key(5'd6); wr(CH_DISP, 15'h0055);
    go(); rd(CH_STAT, 15'h2002, "pre_reset_stat");
    expect_val(1, 15'h0001, "pre_reset_valid");
    go(); reset = 1'b1; rd(CH_TIMER, 15'h0000, "async_rst_timer");
    expect_val(1, 15'h0000, "async_rst_valid");
    expect_val(2, 15'h0000, "async_rst_data");
    go(); rd(CH_STAT, 15'h0000, "async_rst_stat"); push_key(5'd9);
    go(); rd(CH_GEN0, 15'h0000, "async_rst_gen0"); wr(CH_GEN1, 15'h5555);
    go(); reset = 1'b0; rd(CH_GEN1, 15'h0000, "rst_write_ignored");
    go(); rd(CH_STAT, 15'h0000, "rst_key_ignored");
    go();

    @(negedge clock);
    #1;
    total++;
    if (kind_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", kind_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_channel_bank.md
IO_CHANNEL_BANK -- requirements
Module: io_channel_bank

Interface
REQ-001 Parameter: KEY_DEPTH, default 4, keycode FIFO depth, power of two, 2..16.
REQ-002 Parameter: TIMER_W, default 15, timer channel width, fixed at the 15-bit word width.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 IO_read_sel  input  3  channel selected for read.
REQ-006 IO_read_en  input  1  read strobe; pops the keycode FIFO when channel 0 is selected.
REQ-007 IO_read_data  output  15  data of the selected channel, combinational from IO_read_sel and state.
REQ-008 IO_write_sel  input  3  channel selected for write.
REQ-009 IO_write_en  input  1  write strobe.
REQ-010 IO_write_data  input  15  write data.
REQ-011 key_valid  input  1  keypad keycode present this cycle (single-cycle pulse).
REQ-012 key_code  input  5  keypad keycode.
REQ-013 disp_valid  output  1  display word pending.
REQ-014 disp_ready  input  1  display accepts the word.
REQ-015 disp_data  output  15  display word.

Function
REQ-016 Channel map: 0 keycode pop; 1 status; 2-5 general registers; 6 display; 7 timer.
REQ-017 Channel 0 read returns {10'b0, FIFO head}, or 0 when the FIFO is empty; IO_read_en with sel=0 pops one entry when the FIFO is not empty.
REQ-018 Popping an empty FIFO has no effect and sets no flag.
REQ-019 key_valid pushes key_code when the FIFO is not full; a push while full drops the code and sets the sticky overflow flag.
REQ-020 A simultaneous push and pop while full completes both (count unchanged, no overflow); a simultaneous push and pop while empty pushes only.
REQ-021 Channel 1 read returns {overflow[14], disp_busy[13], 8'b0, count[4:0]}, where count is the number of valid FIFO entries.
REQ-022 Writing channel 1 with bit 14 set clears overflow; all other bits are ignored.
REQ-023 Channels 2-5: a write loads the 15-bit register on the next edge, and a read returns the stored value.
REQ-024 Display state machine, states IDLE and SEND. In IDLE, a channel 6 write latches disp_data and moves to SEND. In SEND, disp_valid=1; disp_ready returns to IDLE on the same edge.
REQ-025 A channel 6 write in SEND is dropped and disp_data holds; disp_busy = (state==SEND).
REQ-026 Channel 6 read returns the last latched disp_data.
REQ-027 Channel 7 is a free-running 15-bit timer: +1 per cycle, wraps 7FFF->0000.
REQ-028 A channel 7 write loads IO_write_data; the timer then increments from that value on the following cycle, and the write takes priority over the increment.
REQ-029 A read and a write to the same channel in the same cycle: the read returns the pre-write value.
REQ-030 An undecoded select cannot occur (3-bit select, 8 channels used).

Reset
REQ-031 On reset assertion, immediately: FIFO empty, pointers 0, overflow 0, channels 2-5 = 0, timer 0, display state IDLE, disp_valid 0, disp_data 0.
REQ-032 Reset asserted mid-SEND drops the pending display word without a handshake.
REQ-033 key_valid and IO strobes during reset are ignored.

Structure
REQ-034 A shared package holds the channel-number constants (CH_KEY, CH_STAT, CH_GEN0..3, CH_DISP, CH_TIMER), the status bit positions and the display-state enum.
REQ-035 The keycode FIFO is a sub-module keycode_fifo (push, pop, full, empty, count, head) instantiated once; all other logic is inline.

Verification
REQ-036 Push codes 3,7,9 -> status count=3; three reads of channel 0 with pops -> 3,7,9; count=0; a further pop -> data 0, no flag.
REQ-037 Push 5 codes with KEY_DEPTH=4 -> overflow=1, count=4, fifth code lost; write ch1=4000 -> overflow=0.
REQ-038 Full FIFO with push and pop in the same cycle -> count stays 4, overflow stays 0, pushed code appears last.
REQ-039 Write ch6=1234 with disp_ready=0 for 5 cycles -> disp_valid held high, disp_data=1234; a ch6 write of 0777 is ignored; disp_ready=1 -> IDLE next cycle, busy=0.
REQ-040 Write ch7=7FFE -> reads give 7FFF, then 0000 on consecutive cycles.
REQ-041 Assert reset while in SEND with FIFO count 2 -> disp_valid=0, count=0, timer=0 immediately, without waiting for a clock edge.
